// File: rtl/mips_fetch_queue_if.sv
// Bus bundle for the instruction-prefetch unit: the Avalon read master
// towards memory plus the valid/ready instruction stream and redirect
// channel towards the core's decode stage.
interface mips_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    // Avalon master side
    logic [31:0]   address;
    logic          read;
    logic [3:0]    byteenable;
    logic          waitrequest;
    logic [31:0]   readdata;

    // Core side
    logic          active;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] count;

    // The fetch unit itself
    modport master (
        output address, read, byteenable, active,
               instr, instr_pc, instr_valid, count,
        input  waitrequest, readdata, instr_ready,
               redirect_valid, redirect_pc
    );

    // Memory + core environment around the fetch unit
    modport slave (
        input  address, read, byteenable, active,
               instr, instr_pc, instr_valid, count,
        output waitrequest, readdata, instr_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/mips_fetch_queue.sv
// Instruction-prefetch unit for the multicycle MIPS core. Owns the fetch PC,
// streams sequential word reads over Avalon and buffers them in a DEPTH-entry
// circular queue. Redirects flush the queue; a read already on the bus is
// drained (its data dropped) before fetching resumes. Redirect to 0 halts.
module mips_fetch_queue #(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic               clk,
    input  logic               reset,
    mips_fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    state_t        state_q,    state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;   // address of the current/next request
    logic [31:0]   target_q,   target_d;     // where to resume after a drain
    logic          pending_q,  pending_d;    // request stalled by waitrequest
    logic [CW-1:0] count_q,    count_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    entry_t        mem_q [DEPTH];

    logic          read_o;
    logic          active_o;
    logic          instr_valid_o;
    logic          push;
    logic          pop;
    logic          complete;
    logic          stall;
    logic [31:0]   new_pc;
    logic [31:0]   drain_tgt;
    entry_t        head;

    assign new_pc        = bus.redirect_pc & ~32'h3;
    assign instr_valid_o = (count_q != '0) && (state_q != HALT);
    assign pop           = instr_valid_o & bus.instr_ready;
    assign complete      = read_o & ~bus.waitrequest;
    assign stall         = read_o & bus.waitrequest;
    assign head          = mem_q[rd_ptr_q];

    // Next-state, bus request and queue bookkeeping
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        pending_d  = pending_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        read_o     = 1'b0;
        active_o   = 1'b0;
        push       = 1'b0;
        drain_tgt  = target_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                active_o  = 1'b1;
                read_o    = pending_q | (count_q < FULL);
                pending_d = read_o & bus.waitrequest;
                if (bus.redirect_valid) begin
                    // Flush swallows any same-cycle pop and push.
                    count_d  = '0;
                    rd_ptr_d = wr_ptr_q;
                    if (stall) begin
                        // Request must stay on the bus; keep its address.
                        state_d  = DRAIN;
                        target_d = new_pc;
                    end else begin
                        fetch_pc_d = new_pc;
                        pending_d  = 1'b0;
                        if (new_pc == 32'h0)
                            state_d = HALT;
                    end
                end else begin
                    push    = complete;
                    count_d = count_q + CW'(push) - CW'(pop);
                    if (push) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        wr_ptr_d   = wr_ptr_q + PW'(1);
                    end
                    if (pop)
                        rd_ptr_d = rd_ptr_q + PW'(1);
                end
            end

            DRAIN: begin
                active_o  = 1'b1;
                read_o    = 1'b1;
                drain_tgt = bus.redirect_valid ? new_pc : target_q;
                target_d  = drain_tgt;
                if (complete) begin
                    fetch_pc_d = drain_tgt;
                    pending_d  = 1'b0;
                    state_d    = (drain_tgt == 32'h0) ? HALT : FETCH;
                end
            end

            HALT: begin
                // Parked until reset; redirects are ignored.
            end

            default: state_d = IDLE;
        endcase
    end

    // State and pointer registers
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before this edge.
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_VECTOR;
            target_q   <= RESET_VECTOR;
            pending_q  <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            pending_q  <= pending_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Queue storage write
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count gates every read of it, so stale
        // contents are never observed.
        if (push)
            mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, data: bus.readdata};
    end

    assign bus.address     = fetch_pc_q;
    assign bus.read        = read_o;
    assign bus.byteenable  = 4'hF;
    assign bus.active      = active_o;
    assign bus.instr       = head.data;
    assign bus.instr_pc    = head.pc;
    assign bus.instr_valid = instr_valid_o;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_mips_fetch_queue.sv
// Directed bench for mips_fetch_queue (DEPTH=4). Memory is zero-latency
// unless stalled and returns ~address as the instruction word.
module tb_mips_fetch_queue;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic wreq  = 1'b0;
    int   total = 0;
    int   bad   = 0;

    mips_fetch_queue_if #(.DEPTH(4)) bus ();

    assign bus.waitrequest = wreq;
    assign bus.readdata    = ~bus.address;

    mips_fetch_queue #(.DEPTH(4), .RESET_VECTOR(32'hBFC00000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;      // instr_ready driven this cycle
        logic        rd;       // expected read
        logic [31:0] addr;     // expected address
        logic        iv;       // expected instr_valid
        logic [31:0] pc;       // expected instr_pc when iv
        int          cnt;      // expected count
        logic        act;      // expected active
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic rd, input logic [31:0] addr,
                              input logic iv, input logic [31:0] pc, input int cnt,
                              input logic act, input bit chk_addr);
        check({tag, ".read"},        32'(bus.read),        32'(rd));
        if (chk_addr)
            check({tag, ".address"}, bus.address,          addr);
        check({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(iv));
        check({tag, ".count"},       32'(bus.count),       32'(cnt));
        check({tag, ".active"},      32'(bus.active),      32'(act));
        if (iv) begin
            check({tag, ".instr_pc"}, bus.instr_pc, pc);
            check({tag, ".instr"},    bus.instr,    ~pc);
        end
    endtask

    // Drive inputs for the current cycle, then move to the next negedge.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic w);
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        wreq               = w;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        wreq               = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Streaming fill, full stop, single pops (cycle 0 = first after release)
        vecs[0]  = '{1'b0, 1'b0, 32'hBFC00000, 1'b0, 32'h0,         0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'hBFC00000, 1'b0, 32'h0,         0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 32'hBFC00004, 1'b1, 32'hBFC00000, 1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 32'hBFC00008, 1'b1, 32'hBFC00000, 2, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'hBFC0000C, 1'b1, 32'hBFC00000, 3, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'hBFC00010, 1'b1, 32'hBFC00000, 4, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'hBFC00010, 1'b1, 32'hBFC00000, 4, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'hBFC00010, 1'b1, 32'hBFC00004, 3, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'hBFC00014, 1'b1, 32'hBFC00004, 4, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 32'hBFC00014, 1'b1, 32'hBFC00008, 3, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'hBFC00018, 1'b1, 32'hBFC0000C, 3, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'hBFC0001C, 1'b1, 32'hBFC0000C, 4, 1'b1};

        do_reset();
        check("byteenable", 32'(bus.byteenable), 32'hF);
        for (int i = 0; i < 12; i++) begin
            expect_out($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].iv,
                       vecs[i].pc, vecs[i].cnt, vecs[i].act, 1'b1);
            step(vecs[i].rdy, 1'b0, 32'h0, 1'b0);
        end

        // Stall on BFC00008 for five cycles, then redirect during a stall
        do_reset();
        step(0, 0, 0, 0);
        expect_out("s1", 1, 32'hBFC00000, 0, 0, 0, 1, 1);  step(0, 0, 0, 0);
        expect_out("s2", 1, 32'hBFC00004, 1, 32'hBFC00000, 1, 1, 1); step(0, 0, 0, 0);
        expect_out("s3", 1, 32'hBFC00008, 1, 32'hBFC00000, 2, 1, 1); step(0, 0, 0, 1);
        for (int k = 4; k <= 7; k++) begin
            expect_out($sformatf("stall%0d", k), 1, 32'hBFC00008, 1, 32'hBFC00000, 2, 1, 1);
            step(0, 0, 0, 1);
        end
        expect_out("s8", 1, 32'hBFC00008, 1, 32'hBFC00000, 2, 1, 1); step(0, 0, 0, 0);
        expect_out("s9", 1, 32'hBFC0000C, 1, 32'hBFC00000, 3, 1, 1); step(0, 0, 0, 1);
        expect_out("s10", 1, 32'hBFC0000C, 1, 32'hBFC00000, 3, 1, 1);
        step(0, 1, 32'h00001000, 1);
        expect_out("drain1", 1, 32'hBFC0000C, 0, 0, 0, 1, 1); step(0, 0, 0, 1);
        expect_out("drain2", 1, 32'hBFC0000C, 0, 0, 0, 1, 1); step(0, 0, 0, 0);
        expect_out("newtgt", 1, 32'h00001000, 0, 0, 0, 1, 1); step(0, 0, 0, 0);
        expect_out("newhead", 1, 32'h00001004, 1, 32'h00001000, 1, 1, 1);

        // Redirect while the current read completes: data dropped, low bits cleared
        step(0, 1, 32'h00002003, 0);
        expect_out("rc1", 1, 32'h00002000, 0, 0, 0, 1, 1); step(0, 0, 0, 0);
        expect_out("rc2", 1, 32'h00002004, 1, 32'h00002000, 1, 1, 1); step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        expect_out("full", 0, 32'h00002010, 1, 32'h00002000, 4, 1, 1);

        // Pop + redirect while full; then push + pop + redirect together
        step(1, 1, 32'h00003000, 0);
        expect_out("fr1", 1, 32'h00003000, 0, 0, 0, 1, 1); step(1, 0, 0, 0);
        expect_out("fr2", 1, 32'h00003004, 1, 32'h00003000, 1, 1, 1);
        step(1, 1, 32'h00004000, 0);
        expect_out("ppr1", 1, 32'h00004000, 0, 0, 0, 1, 1); step(0, 0, 0, 0);
        expect_out("ppr2", 1, 32'h00004004, 1, 32'h00004000, 1, 1, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        expect_out("full2", 0, 32'h00004010, 1, 32'h00004000, 4, 1, 1);

        // Redirect to 0 with an idle bus halts; later redirects are ignored
        step(0, 1, 32'h0, 0);
        expect_out("halt1", 0, 0, 0, 0, 0, 0, 0); step(1, 1, 32'h00001000, 0);
        expect_out("halt2", 0, 0, 0, 0, 0, 0, 0); step(1, 0, 0, 0);
        expect_out("halt3", 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a stalled read
        do_reset();
        step(0, 0, 0, 1);
        expect_out("ar1", 1, 32'hBFC00000, 0, 0, 0, 1, 1); step(0, 0, 0, 1);
        expect_out("ar2", 1, 32'hBFC00000, 0, 0, 0, 1, 1);
        reset = 1'b1;
        #1;
        expect_out("ar_rst", 0, 32'hBFC00000, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
